// File: rtl/fdct_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fdct_pkg
// Brief    : Shared widths, state encoding and sample type for the FDCT row
//            butterfly stage.
// Revision : 1.0 - initial release
// ============================================================================
package fdct_pkg;

  localparam int c_width_in = 8;
  localparam int c_n        = 8;
  localparam int c_sum_w    = c_width_in + 1;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef logic signed [c_width_in-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/fdct_row_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fdct_row_buffer
// Brief    : One-row sample store, one write port and two combinational reads.
// Revision : 1.0 - initial release
// ============================================================================
module fdct_row_buffer
  import fdct_pkg::*;
#(
  parameter int WIDTH = c_width_in,
  parameter int DEPTH = c_n
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr_a,
  input  logic [$clog2(DEPTH)-1:0] raddr_b,
  output logic [WIDTH-1:0]         rdata_a,
  output logic [WIDTH-1:0]         rdata_b
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata_a = r_mem[raddr_a];
  assign rdata_b = r_mem[raddr_b];

endmodule
`default_nettype wire

// File: rtl/fdct_butterfly_stage.sv
`default_nettype none
// ============================================================================
// Module   : fdct_butterfly_stage
// Brief    : Collects an 8-sample row, then emits 4 registered butterfly beats
//            (x[i]+x[7-i], x[i]-x[7-i]) with downstream backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module fdct_butterfly_stage
  import fdct_pkg::*;
#(
  parameter int WIDTH_IN = c_width_in,
  parameter int N        = c_n
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH_IN-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH_IN:0]   out_sum,
  output logic [WIDTH_IN:0]   out_diff,
  output logic [1:0]          out_idx,
  output logic                out_last,
  output logic                frame_err
);

  localparam int c_sw = WIDTH_IN + 1;

  generate
    if (N != 8) begin : g_bad_n
      $error("fdct_butterfly_stage supports only N == 8");
    end
  endgenerate

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_wr_cnt;
  logic [1:0]        r_rd_cnt;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_frame_err;
  logic [c_sw-1:0]   r_out_sum;
  logic [c_sw-1:0]   r_out_diff;

  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_fill_done;
  logic              w_drain_done;
  logic              w_load;
  logic [1:0]        w_next_idx;
  logic [2:0]        w_raddr_a;
  logic [2:0]        w_raddr_b;
  logic [WIDTH_IN-1:0] w_rdata_a;
  logic [WIDTH_IN-1:0] w_rdata_b;
  logic [WIDTH_IN-1:0] w_op_b;
  logic [c_sw-1:0]   w_ext_a;
  logic [c_sw-1:0]   w_ext_b;

  assign w_in_ready   = (r_state == FILL) && reset;
  assign w_in_xfer    = in_valid && w_in_ready;
  assign w_out_xfer   = r_out_valid && out_ready;
  assign w_fill_done  = w_in_xfer && (r_wr_cnt == 3'd7);
  assign w_drain_done = w_out_xfer && (r_rd_cnt == 2'd3);
  assign w_load       = w_fill_done || (w_out_xfer && (r_rd_cnt != 2'd3));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_fill_done)  w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_done) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  // Output registers are loaded with the *next* beat, so the first beat pairs
  // buf[0] with the 8th sample straight off the input bus.
  assign w_next_idx = (r_state == FILL) ? 2'd0 : (r_rd_cnt + 2'd1);
  assign w_raddr_a  = {1'b0, w_next_idx};
  assign w_raddr_b  = 3'd7 - w_raddr_a;
  assign w_op_b     = (r_state == FILL) ? in_data : w_rdata_b;
  assign w_ext_a    = {w_rdata_a[WIDTH_IN-1], w_rdata_a};
  assign w_ext_b    = {w_op_b[WIDTH_IN-1], w_op_b};

  fdct_row_buffer #(
    .WIDTH (WIDTH_IN),
    .DEPTH (N)
  ) u_row_buffer (
    .clk     (clk),
    .we      (w_in_xfer),
    .waddr   (r_wr_cnt),
    .wdata   (in_data),
    .raddr_a (w_raddr_a),
    .raddr_b (w_raddr_b),
    .rdata_a (w_rdata_a),
    .rdata_b (w_rdata_b)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_cnt    <= 3'd0;
      r_rd_cnt    <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_frame_err <= 1'b0;
      r_out_sum   <= '0;
      r_out_diff  <= '0;
    end else begin
      if (w_in_xfer) begin
        if (r_wr_cnt == 3'd7) begin
          r_wr_cnt <= 3'd0;
          if (!in_last) r_frame_err <= 1'b1;
        end else if (in_last) begin
          r_wr_cnt    <= 3'd0;
          r_frame_err <= 1'b1;
        end else begin
          r_wr_cnt <= r_wr_cnt + 3'd1;
        end
      end
      if (w_fill_done) begin
        r_rd_cnt    <= 2'd0;
        r_out_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_rd_cnt <= r_rd_cnt + 2'd1;
        if (w_drain_done) r_out_valid <= 1'b0;
      end
      if (w_load) begin
        r_out_sum  <= w_ext_a + w_ext_b;
        r_out_diff <= w_ext_a - w_ext_b;
        r_out_last <= (w_next_idx == 2'd3);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_diff  = r_out_diff;
  assign out_idx   = r_rd_cnt;
  assign out_last  = r_out_last;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_fdct_butterfly_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fdct_butterfly_stage
// Brief    : Scoreboard bench: row-level reference model feeds an expected-beat
//            queue, an independent monitor pops and compares each output beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fdct_butterfly_stage;
  import fdct_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_data = 8'd0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [c_sum_w-1:0] out_sum;
  logic [c_sum_w-1:0] out_diff;
  logic [1:0]        out_idx;
  logic              out_last;
  logic              frame_err;

  fdct_butterfly_stage #(.WIDTH_IN(8), .N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_diff  (out_diff),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int diff;
    int idx;
    int last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    row_m[8];
  int    cnt_m = 0;
  int    ferr_m = 0;
  int    ready_mode = 0;
  logic  ready_force = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sole driver of out_ready: forced level or random backpressure.
  always @(posedge clk) begin
    #2;
    if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                 out_ready = ready_force;
  end

  // Monitor: pops one expected beat per accepted output, checks hold on stall.
  beat_t      e;
  bit         stalled = 1'b0;
  logic [8:0] p_sum, p_diff;
  logic [1:0] p_idx;
  logic       p_last;
  always @(negedge clk) begin
    if (reset && out_valid) begin
      chk("in_ready_low_in_drain", int'(in_ready), 0);
      if (stalled) begin
        chk("hold_sum", int'(out_sum), int'(p_sum));
        chk("hold_diff", int'(out_diff), int'(p_diff));
        chk("hold_idx", int'(out_idx), int'(p_idx));
        chk("hold_last", int'(out_last), int'(p_last));
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got idx %0d expected no beat", out_idx);
        end else begin
          e = exp_q.pop_front();
          chk("beat_sum", int'($signed(out_sum)), e.sum);
          chk("beat_diff", int'($signed(out_diff)), e.diff);
          chk("beat_idx", int'(out_idx), e.idx);
          chk("beat_last", int'(out_last), e.last);
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        p_sum  = out_sum;
        p_diff = out_diff;
        p_idx  = out_idx;
        p_last = out_last;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // Row-level model: a complete row of 8 yields 4 butterfly pairs.
  task automatic model_accept(input int d, input bit last);
    row_m[cnt_m] = d;
    if (cnt_m == 7) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back('{sum: row_m[i] + row_m[7-i], diff: row_m[i] - row_m[7-i],
                          idx: i, last: (i == 3) ? 1 : 0});
      end
      cnt_m = 0;
      if (!last) ferr_m = 1;
    end else if (last) begin
      ferr_m = 1;
      cnt_m  = 0;
    end else begin
      cnt_m++;
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send_sample(input int d, input bit last);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d[7:0];
    in_last  = last;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      n++;
      if (!ok) begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ok) model_accept(d, last);
  endtask

  task automatic send_row(input int v[8], input bit last8);
    for (int k = 0; k < 8; k++) send_sample(v[k], (k == 7) ? last8 : 1'b0);
    @(negedge clk);
    chk("first_beat_latency", int'(out_valid), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_complete", (n < 400) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_row(output int v[8]);
    for (int k = 0; k < 8; k++) v[k] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int r[8];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_diff", int'(out_diff), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    ready_mode  = 0;
    ready_force = 1'b1;

    r = '{10, 20, 30, 40, 50, 60, 70, 80};
    send_row(r, 1'b1);
    wait_idle();
    chk("ferr_clean_row", int'(frame_err), ferr_m);

    r = '{-128, 0, 0, 0, 0, 0, 0, 127};
    send_row(r, 1'b1);
    r = '{127, 0, 0, 0, 0, 0, 0, -128};
    send_row(r, 1'b1);
    wait_idle();

    // Stall beat 1 for three cycles.
    ready_force = 1'b0;
    rand_row(r);
    send_row(r, 1'b1);
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    ready_force = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("bp_idx_held", int'(out_idx), 1);
    chk("bp_valid_held", int'(out_valid), 1);
    ready_force = 1'b1;
    wait_idle();

    for (int k = 0; k < 5; k++) send_sample(k * 3 + 1, k == 4);
    @(negedge clk);
    chk("early_last_no_valid", int'(out_valid), 0);
    chk("early_last_ferr", int'(frame_err), ferr_m);
    @(posedge clk);
    #1;
    rand_row(r);
    send_row(r, 1'b1);
    wait_idle();
    chk("ferr_sticky", int'(frame_err), ferr_m);

    rand_row(r);
    send_row(r, 1'b0);
    wait_idle();
    chk("missing_last_ferr", int'(frame_err), ferr_m);

    for (int k = 0; k < 4; k++) send_sample(k + 100, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_during_reset", int'(in_ready), 0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    cnt_m  = 0;
    ferr_m = 0;
    @(negedge clk);
    chk("post_rst_valid", int'(out_valid), 0);
    chk("post_rst_sum", int'(out_sum), 0);
    chk("post_rst_ferr", int'(frame_err), ferr_m);
    chk("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rand_row(r);
    send_row(r, 1'b1);
    wait_idle();
    chk("ferr_after_reset_row", int'(frame_err), ferr_m);

    ready_mode = 1;
    repeat (10) begin
      rand_row(r);
      send_row(r, 1'b1);
    end
    wait_idle();
    ready_mode = 0;
    chk("queue_empty", exp_q.size(), 0);
    chk("ferr_final", int'(frame_err), ferr_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
